// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR): stage k applies the 2^k step, final stage also
// resolves oversize amounts and illegal ops. Latency LOG2W; the whole pipe holds while the output stalls.
module shift_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int L     = LOG2W;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic [2:0]       op;
    logic             sign;
    logic             big;
    logic [LOG2W-1:0] amt;
  } meta_t;

  logic [WIDTH-1:0] dat_q   [L];
  logic [WIDTH-1:0] dat_d   [L];
  logic [WIDTH-1:0] src_dat [L];
  meta_t            meta_q  [L];
  meta_t            src_meta[L];
  logic             vld_q   [L];
  logic             vld_d   [L];
  meta_t            fin;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             advance;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       op,
                                                  input logic             sign,
                                                  input int               sh);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    case (op)
      OP_SLL:  r = d << sh;
      OP_SRL:  r = d >> sh;
      // fill comes from the sign captured at entry, not the current MSB
      OP_SRA:  r = (d >> sh) | (sign ? ~(ones >> sh) : '0);
      OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
      OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    advance  = !vld_q[L-1] || out_ready;
    in_ready = advance && !rst;

    src_dat[0]       = in_a;
    src_meta[0].op   = in_op;
    src_meta[0].sign = in_a[WIDTH-1];
    src_meta[0].big  = |in_b[WIDTH-1:LOG2W];
    src_meta[0].amt  = in_b[LOG2W-1:0];
    vld_d[0]         = in_valid && in_ready;
    for (int k = 1; k < L; k++) begin
      src_dat[k]  = dat_q[k-1];
      src_meta[k] = meta_q[k-1];
      vld_d[k]    = vld_q[k-1];
    end

    for (int k = 0; k < L; k++) begin
      dat_d[k] = shift_step(src_dat[k], src_meta[k].op, src_meta[k].sign,
                            src_meta[k].amt[k] ? (1 << k) : 0);
    end

    // Last stage overrides the shifted value for oversize amounts and illegal ops.
    fin   = src_meta[L-1];
    err_d = (fin.op > OP_ROR);
    if (err_d) begin
      dat_d[L-1] = '0;
    end else if (fin.big && (fin.op == OP_SLL || fin.op == OP_SRL)) begin
      dat_d[L-1] = '0;
    end else if (fin.big && fin.op == OP_SRA) begin
      dat_d[L-1] = {WIDTH{fin.sign}};
    end
    zero_d = (dat_d[L-1] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        vld_q[k]  <= 1'b0;
        dat_q[k]  <= '0;
        meta_q[k] <= '0;
      end
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < L; k++) begin
        vld_q[k]  <= vld_d[k];
        dat_q[k]  <= dat_d[k];
        meta_q[k] <= src_meta[k];
      end
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_data  = dat_q[L-1];
  assign out_zero  = zero_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe (WIDTH=8): directed spec vectors, streaming, stalls, reset flush and
// random traffic, all scored against an arithmetic reference model.
module tb_shift_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [2:0] in_op = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_err;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  int emitted = 0;
  logic [9:0] exp_q[$];

  shift_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {err, zero, data}.
  function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    logic [7:0]  r;
    logic [15:0] w;
    int          n;
    n = b % 8;
    r = 8'h00;
    case (op)
      3'd0: r = (b >= 8) ? 8'h00 : (a << b);
      3'd1: r = (b >= 8) ? 8'h00 : (a >> b);
      3'd2: if (b >= 8) r = {8{a[7]}}; else r = $signed(a) >>> b;
      3'd3: begin w = {a, a} << n; r = w[15:8]; end
      3'd4: begin w = {a, a} >> n; r = w[7:0]; end
      default: return {1'b1, 1'b1, 8'h00};
    endcase
    return {1'b0, r == 8'h00, r};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!out_valid) chk("rdy_idle", in_ready, 1);
      else if (!out_ready) chk("rdy_stall", in_ready, 0);
      if (out_valid) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("out_data", out_data, exp_q[0][7:0]);
          chk("out_zero", out_zero, exp_q[0][8]);
          chk("out_err", out_err, exp_q[0][9]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            emitted++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_a, in_b, in_op));
        accepted++;
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic dir(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input logic [7:0] exp_dat, input logic exp_zero,
                     input logic exp_err);
    drive(a, b, op);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, out_valid, (i == 3));
    end
    chk({tag, "_dat"}, out_data, exp_dat);
    chk({tag, "_zero"}, out_zero, exp_zero);
    chk({tag, "_err"}, out_err, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxr;
    int run;
    int snap;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_err", out_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    dir("sll",      8'h81, 8'h01, 3'd0, 8'h02, 1'b0, 1'b0);
    dir("sra2",     8'h90, 8'h02, 3'd2, 8'hE4, 1'b0, 1'b0);
    dir("sra_big",  8'h90, 8'h10, 3'd2, 8'hFF, 1'b0, 1'b0);
    dir("srl_big",  8'h90, 8'h08, 3'd1, 8'h00, 1'b1, 1'b0);
    dir("rol9",     8'h81, 8'h09, 3'd3, 8'h03, 1'b0, 1'b0);
    dir("ror1",     8'h01, 8'h01, 3'd4, 8'h80, 1'b0, 1'b0);
    dir("illegal",  8'h5A, 8'h03, 3'd7, 8'h00, 1'b1, 1'b1);
    dir("sra0",     8'h90, 8'h00, 3'd2, 8'h90, 1'b0, 1'b0);
    dir("sll7",     8'hFF, 8'h07, 3'd0, 8'h80, 1'b0, 1'b0);
    dir("ror_mod",  8'h81, 8'h10, 3'd4, 8'h81, 1'b0, 1'b0);
    dir("srl7",     8'hC3, 8'h07, 3'd1, 8'h01, 1'b0, 1'b0);

    // Back-to-back stream: expect exactly 8 consecutive valid cycles
    maxr = 0;
    run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(8'($urandom), 8'($urandom_range(0, 7)), 3'($urandom_range(0, 4)));
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (out_valid) run++; else run = 0;
          if (run > maxr) maxr = run;
        end
      end
    join
    chk("stream_run", maxr, 8);
    drain("stream");

    // Output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(8'($urandom), 8'($urandom_range(0, 9)), 3'($urandom_range(0, 4)));
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall");
    chk("stall_no_loss", emitted, accepted);

    // Random traffic with random backpressure; unaccepted beats are held
    for (int c = 0; c < 400; c++) begin
      bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 8'($urandom);
        in_b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        in_op = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("random");
    chk("random_no_loss", emitted, accepted);

    // Reset with three beats in flight
    out_ready = 1'b1;
    drive(8'h0F, 8'h01, 3'd0);
    drive(8'h12, 8'h00, 3'd6);
    drive(8'hF0, 8'h02, 3'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    snap = emitted;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_out_zero", out_zero, 0);
    chk("flush_out_err", out_err, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_no_stale", emitted - snap, 0);
    dir("post_rst", 8'h81, 8'h01, 3'd3, 8'h03, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
